// File: rtl/led_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_seq_pkg : mode encodings, seeds and pattern-step helpers          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package led_seq_pkg;

    localparam logic [1:0] MODE_ROTL   = 2'b00;
    localparam logic [1:0] MODE_ROTR   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam logic [7:0] SEED_ROTL   = 8'h01;
    localparam logic [7:0] SEED_ROTR   = 8'h80;
    localparam logic [7:0] SEED_BOUNCE = 8'h01;
    localparam logic [7:0] SEED_COUNT  = 8'h00;
    localparam logic [7:0] RESET_LEDS  = 8'h01;

    typedef struct packed {
        logic [7:0] leds;
        logic       dir;
    } pattern_t;

    // Only bounce owns dir; every other mode passes it through untouched.
    function automatic pattern_t seed_pattern(input logic [1:0] mode, input logic dir);
        pattern_t p;
        p.dir = dir;
        case (mode)
            MODE_ROTL:   p.leds = SEED_ROTL;
            MODE_ROTR:   p.leds = SEED_ROTR;
            MODE_BOUNCE: begin
                p.leds = SEED_BOUNCE;
                p.dir  = 1'b1;
            end
            default:     p.leds = SEED_COUNT;
        endcase
        return p;
    endfunction

    function automatic pattern_t next_pattern(input logic [1:0] mode, input pattern_t cur);
        pattern_t n;
        n = cur;
        case (mode)
            MODE_ROTL: n.leds = {cur.leds[6:0], cur.leds[7]};
            MODE_ROTR: n.leds = {cur.leds[0], cur.leds[7:1]};
            MODE_BOUNCE: begin
                if (cur.dir) begin
                    if (cur.leds[7]) begin
                        n.leds = 8'h40;
                        n.dir  = 1'b0;
                    end else begin
                        n.leds = cur.leds << 1;
                    end
                end else begin
                    if (cur.leds[0]) begin
                        n.leds = 8'h02;
                        n.dir  = 1'b1;
                    end else begin
                        n.leds = cur.leds >> 1;
                    end
                end
            end
            default:   n.leds = cur.leds + 8'd1;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_edge_detect : tick_in synchronizer with registered rise detect   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_edge;

    // r_fill marks when the chain holds real samples; arming only after a
    // genuine low sample stops a tick held high across reset from counting.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev <= r_sync[SYNC_STAGES-1];
            if (r_fill[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
            r_edge <= r_armed & r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign edge_pulse = r_edge;

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_sequencer : tick-driven 8-bit LED pattern generator               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic [1:0] mode,
    input  logic [3:0] step_div,
    input  logic       pause,
    output logic [7:0] leds,
    output logic       step_pulse,
    output logic       dir
);

    logic       w_edge;
    logic       w_step;
    pattern_t   w_next;
    pattern_t   r_pat;
    logic [1:0] r_mode_q;
    logic [3:0] r_cnt;
    logic       r_step_pulse;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_in    (tick_in),
        .edge_pulse (w_edge)
    );

    assign w_step = w_edge & ~pause & (r_cnt >= step_div);

    // A mode change takes effect as a reseed rather than an advance.
    always_comb begin
        w_next = r_pat;
        if (mode != r_mode_q) begin
            w_next = seed_pattern(mode, r_pat.dir);
        end else begin
            w_next = next_pattern(mode, r_pat);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_pat.leds   <= RESET_LEDS;
            r_pat.dir    <= 1'b1;
            r_mode_q     <= MODE_ROTL;
            r_cnt        <= 4'd0;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= w_step;
            if (w_edge && !pause) begin
                if (w_step) begin
                    r_cnt    <= 4'd0;
                    r_mode_q <= mode;
                    r_pat    <= w_next;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign leds       = r_pat.leds;
    assign dir        = r_pat.dir;
    assign step_pulse = r_step_pulse;

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on tick_in (minimum 2).
REQ-002 SHALL have port clk_in  input  1  system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port tick_in  input  1  divided clock from clock_div; treated as asynchronous data, never used as a clock.
REQ-005 SHALL have port mode  input  2  pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count.
REQ-006 SHALL have port step_div  input  4  steps occur on every (step_div+1)th tick_in rising edge.
REQ-007 SHALL have port pause  input  1  when 1, tick edges are ignored and all pattern state holds.
REQ-008 SHALL have port leds  output  8  current LED pattern, registered.
REQ-009 SHALL have port step_pulse  output  1  high for exactly one clk_in cycle per pattern update, registered.
REQ-010 SHALL have port dir  output  1  bounce direction, 1 = moving toward MSB, registered.

Function
REQ-011 SHALL synchronize tick_in through SYNC_STAGES flops and detect rising edges by comparing the last stage against a delayed copy.
REQ-012 SHALL update leds, and assert step_pulse, at the clk_in edge SYNC_STAGES+1 edges after the edge that first samples tick_in high (3 edges at default).
REQ-013 SHALL keep a 4-bit edge counter: on a detected edge, if counter >= step_div, then step and clear the counter; otherwise increment it.
REQ-014 SHALL step on every detected edge when step_div = 0.
REQ-015 SHALL, when pause = 1, ignore detected edges: counter, leds, dir hold and step_pulse stays 0; the synchronizer keeps running.
REQ-016 SHALL NOT generate a step when pause is deasserted; the next step needs the normal edge count.
REQ-017 SHALL latch mode into mode_q at each step; if mode != mode_q at a step, it SHALL load the new mode's seed instead of advancing.
REQ-018 SHALL use these seeds: rotate-left 8'h01, rotate-right 8'h80, bounce 8'h01 with dir = 1, count 8'h00.
REQ-019 SHALL rotate circularly: left 8'h80 -> 8'h01, right 8'h01 -> 8'h80.
REQ-020 SHALL implement bounce as a single lit bit: at 8'h80 with dir = 1, next is 8'h40 and dir becomes 0; at 8'h01 with dir = 0, next is 8'h02 and dir becomes 1; no bit dwells twice.
REQ-021 SHALL increment modulo 256 in count mode (8'hFF -> 8'h00).
REQ-022 SHALL act on a step_div change at the next detected edge, including a value below the current counter (which steps immediately per REQ-013).
REQ-023 SHALL leave dir unchanged outside bounce mode.

Reset
REQ-024 SHALL, while reset = 0, force: leds 8'h01, dir 1, mode_q 2'b00, counter 0, step_pulse 0, all synchronizer and edge flops 0.
REQ-025 SHALL discard any in-flight tick edge when reset is asserted mid-operation; the first step after release needs a fresh tick_in rising edge.

Structure
REQ-026 SHALL take the mode encodings (MODE_ROTL, MODE_ROTR, MODE_BOUNCE, MODE_COUNT) and the seed constants from shared package led_seq_pkg.
REQ-027 SHALL put the synchronizer plus rising-edge detector in sub-module sync_edge_detect (parameter SYNC_STAGES, output edge_pulse).

Verification
REQ-028 SHALL cover: reset = 0 then released, mode = 00, step_div = 0, tick_in toggling every 80 ns -> leds 01, 02, 04 ... 80, 01, with step_pulse one cycle wide, 3 clk_in edges after each tick_in rise.
REQ-029 SHALL cover: mode = 10, step_div = 0, 16 tick edges -> leds 01, 02 ... 80, 40 ... 01, 02, with dir going 0 at 8'h80 and 1 at 8'h01.
REQ-030 SHALL cover: mode = 11, step_div = 3, 1024 tick edges -> leds 8'h00 after 256 steps (wrap), exactly one step per 4 edges.
REQ-031 SHALL cover: mode 00 -> 01 switched mid-run -> leds 8'h80 at the next step, then 8'h40.
REQ-032 SHALL cover: pause = 1 across 5 tick edges, then 0 -> leds unchanged, no step_pulse during pause, none on release.
REQ-033 SHALL cover: reset pulsed low mid-count while step_div = 7 -> leds 8'h01 immediately, and the next step only after 8 new edges.
